gpu_blitter: RTL and testbench



---
 rtl/gpu_pkg.sv | 30 +++
 rtl/gpu_blitter_raster_iter.sv | 70 +++++++
 rtl/gpu_blitter.sv | 232 +++++++++++++++++++++++
 tb/tb_gpu_blitter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared encodings for the blitter (command modes, one-hot FSM states).
package gpu_pkg;

  typedef enum logic [1:0] {
    MODE_COPY  = 2'd0,
    MODE_FILL  = 2'd1,
    MODE_CLEAR = 2'd2,
    MODE_NOP   = 2'd3
  } mode_e;

  // Bit positions of each state inside the one-hot state vector.
  typedef enum int unsigned {
    S_IDLE  = 0,
    S_FETCH = 1,
    S_WRITE = 2,
    S_FILL  = 3,
    S_FIN   = 4
  } state_idx_e;

  localparam int unsigned NUM_STATES = 5;

  typedef enum logic [NUM_STATES-1:0] {
    ST_IDLE  = NUM_STATES'(1) << S_IDLE,
    ST_FETCH = NUM_STATES'(1) << S_FETCH,
    ST_WRITE = NUM_STATES'(1) << S_WRITE,
    ST_FILL  = NUM_STATES'(1) << S_FILL,
    ST_FIN   = NUM_STATES'(1) << S_FIN
  } state_e;

endpackage

// File: rtl/gpu_blitter_raster_iter.sv
// gpu_raster_iter: row-major i/j pixel counters with last-pixel detection and
// source mirroring. Mirroring is built only when GPU_BLIT_FLIP_EN is defined.
module gpu_raster_iter #(
  parameter int unsigned XW = 11,
  parameter int unsigned YW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [XW-1:0] w_i,
  input  logic [YW-1:0] h_i,
  input  logic          flip_x_i,
  input  logic          flip_y_i,
  output logic [XW-1:0] i_o,
  output logic [YW-1:0] j_o,
  output logic [XW-1:0] sx_o,
  output logic [YW-1:0] sy_o,
  output logic          last_pix_o
);

  logic [XW-1:0] i_q, i_d;
  logic [YW-1:0] j_q, j_d;
  logic          last_col, last_row;

  // Position flags and next counter values (wrap to 0 after the last pixel).
  always_comb begin
    last_col = (i_q == w_i - XW'(1));
    last_row = (j_q == h_i - YW'(1));
    i_d      = i_q;
    j_d      = j_q;
    if (load_i) begin
      i_d = '0;
      j_d = '0;
    end else if (step_i) begin
      if (last_col) begin
        i_d = '0;
        j_d = last_row ? '0 : j_q + YW'(1);
      end else begin
        i_d = i_q + XW'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign i_o        = i_q;
  assign j_o        = j_q;
  assign last_pix_o = last_col & last_row;

`ifdef GPU_BLIT_FLIP_EN
  assign sx_o = flip_x_i ? (w_i - XW'(1) - i_q) : i_q;
  assign sy_o = flip_y_i ? (h_i - YW'(1) - j_q) : j_q;
`else
  logic unused_flip;
  assign unused_flip = flip_x_i ^ flip_y_i;
  assign sx_o        = i_q;
  assign sy_o        = j_q;
`endif

endmodule

// File: rtl/gpu_blitter.sv
// gpu_blitter: COPY/FILL/CLEAR rectangle engine and sole framebuffer writer.
// Optional build macro GPU_BLIT_FLIP_EN enables source mirroring.
module gpu_blitter
  import gpu_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = 400,
  parameter int unsigned FB_HEIGHT = 240,
  parameter int unsigned COLOR_W   = 16,
  parameter int unsigned ADDR_W    = 32,
  localparam int unsigned XW       = $clog2(FB_WIDTH) + 2,
  localparam int unsigned YW       = $clog2(FB_HEIGHT) + 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_mode,
  input  logic [ADDR_W-1:0]  cmd_src_base,
  input  logic [15:0]        cmd_src_x,
  input  logic [15:0]        cmd_src_y,
  input  logic [15:0]        cmd_src_stride,
  input  logic [XW-1:0]      cmd_dst_x,
  input  logic [YW-1:0]      cmd_dst_y,
  input  logic [XW-1:0]      cmd_w,
  input  logic [YW-1:0]      cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic [COLOR_W-1:0] cmd_key,
  input  logic               cmd_key_en,
  input  logic               cmd_flip_x,
  input  logic               cmd_flip_y,
  input  logic [XW-2:0]      clip_x0,
  input  logic [XW-2:0]      clip_x1,
  input  logic [YW-2:0]      clip_y0,
  input  logic [YW-2:0]      clip_y1,
  output logic               mem_read,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [COLOR_W-1:0] mem_data,
  input  logic               mem_valid,
  output logic               fb_write,
  output logic [XW-2:0]      fb_x,
  output logic [YW-2:0]      fb_y,
  output logic [COLOR_W-1:0] fb_color,
  output logic               done
);

  localparam int unsigned         BPP   = COLOR_W / 8;
  localparam logic signed [XW:0]  FBW_S = (XW+1)'(FB_WIDTH);
  localparam logic signed [YW:0]  FBH_S = (YW+1)'(FB_HEIGHT);

  state_e state_q, state_d;

  mode_e               mode_q;
  logic [ADDR_W-1:0]   base_q;
  logic [15:0]         srcx_q, srcy_q, stride_q;
  logic [XW-1:0]       dstx_q, w_q;
  logic [YW-1:0]       dsty_q, h_q;
  logic [COLOR_W-1:0]  color_q, key_q;
  logic                key_en_q, flipx_q, flipy_q;
  logic [XW-2:0]       clipx0_q, clipx1_q;
  logic [YW-2:0]       clipy0_q, clipy1_q;

  logic [XW-2:0]       pix_x_q;
  logic [YW-2:0]       pix_y_q;
  logic [COLOR_W-1:0]  pix_c_q;
  logic                pix_we_q, pix_last_q;

  logic                accept, mem_take, fill_step, key_hit, vis;
  logic [XW-1:0]       eff_w, it_i, it_sx;
  logic [YW-1:0]       eff_h, it_j, it_sy;
  logic                it_last;
  logic signed [XW:0]  cur_x;
  logic signed [YW:0]  cur_y;
  logic [ADDR_W-1:0]   a_row, a_col;

  assign accept   = cmd_valid & (state_q == ST_IDLE);
  assign mem_take = mem_read & mem_valid;
  assign eff_w    = (cmd_mode == MODE_CLEAR) ? XW'(FB_WIDTH)  : cmd_w;
  assign eff_h    = (cmd_mode == MODE_CLEAR) ? YW'(FB_HEIGHT) : cmd_h;

  gpu_raster_iter #(
    .XW (XW),
    .YW (YW)
  ) u_iter (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (accept),
    .step_i     (fill_step | mem_take),
    .w_i        (w_q),
    .h_i        (h_q),
    .flip_x_i   (flipx_q),
    .flip_y_i   (flipy_q),
    .i_o        (it_i),
    .j_o        (it_j),
    .sx_o       (it_sx),
    .sy_o       (it_sy),
    .last_pix_o (it_last)
  );

  // Destination pixel, visibility against screen and clip window, colour key.
  always_comb begin
    cur_x   = $signed({dstx_q[XW-1], dstx_q}) + $signed({1'b0, it_i});
    cur_y   = $signed({dsty_q[YW-1], dsty_q}) + $signed({1'b0, it_j});
    vis     = !cur_x[XW] && (cur_x < FBW_S) &&
              !cur_y[YW] && (cur_y < FBH_S) &&
              (cur_x >= $signed({2'b00, clipx0_q})) && (cur_x < $signed({2'b00, clipx1_q})) &&
              (cur_y >= $signed({2'b00, clipy0_q})) && (cur_y < $signed({2'b00, clipy1_q}));
    key_hit = (mode_q == MODE_COPY) && key_en_q && (mem_data == key_q);
  end

  // Source byte address, truncated to ADDR_W.
  always_comb begin
    a_row    = ADDR_W'(srcy_q) + ADDR_W'(it_sy);
    a_col    = ADDR_W'(srcx_q) + ADDR_W'(it_sx);
    mem_addr = base_q + (a_row * ADDR_W'(stride_q) + a_col) * ADDR_W'(BPP);
  end

  // Command and clip window latch on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= MODE_COPY;
      base_q   <= '0;
      srcx_q   <= '0;
      srcy_q   <= '0;
      stride_q <= '0;
      dstx_q   <= '0;
      dsty_q   <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color_q  <= '0;
      key_q    <= '0;
      key_en_q <= 1'b0;
      flipx_q  <= 1'b0;
      flipy_q  <= 1'b0;
      clipx0_q <= '0;
      clipx1_q <= '0;
      clipy0_q <= '0;
      clipy1_q <= '0;
    end else if (accept) begin
      mode_q   <= mode_e'(cmd_mode);
      base_q   <= cmd_src_base;
      srcx_q   <= cmd_src_x;
      srcy_q   <= cmd_src_y;
      stride_q <= cmd_src_stride;
      dstx_q   <= (cmd_mode == MODE_CLEAR) ? '0 : cmd_dst_x;
      dsty_q   <= (cmd_mode == MODE_CLEAR) ? '0 : cmd_dst_y;
      w_q      <= eff_w;
      h_q      <= eff_h;
      color_q  <= cmd_color;
      key_q    <= cmd_key;
      key_en_q <= cmd_key_en;
      flipx_q  <= cmd_flip_x;
      flipy_q  <= cmd_flip_y;
      clipx0_q <= clip_x0;
      clipx1_q <= clip_x1;
      clipy0_q <= clip_y0;
      clipy1_q <= clip_y1;
    end
  end

  // COPY pixel capture: registered write for the pixel whose data just arrived.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      pix_c_q    <= '0;
      pix_we_q   <= 1'b0;
      pix_last_q <= 1'b0;
    end else if (mem_take) begin
      pix_x_q    <= cur_x[XW-2:0];
      pix_y_q    <= cur_y[YW-2:0];
      pix_c_q    <= mem_data;
      pix_we_q   <= vis && !key_hit;
      pix_last_q <= it_last;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and outputs.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    mem_read  = 1'b0;
    fb_write  = 1'b0;
    fb_x      = pix_x_q;
    fb_y      = pix_y_q;
    fb_color  = pix_c_q;
    done      = 1'b0;
    fill_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_mode == MODE_NOP || eff_w == '0 || eff_h == '0) state_d = ST_FIN;
          else if (cmd_mode == MODE_COPY)                          state_d = ST_FETCH;
          else                                                     state_d = ST_FILL;
        end
      end
      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem_valid) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // The next request overlaps this write; a zero-latency reply is
        // consumed here and chains straight into another write.
        fb_write = pix_we_q;
        mem_read = !pix_last_q;
        if (pix_last_q)     state_d = ST_FIN;
        else if (mem_valid) state_d = ST_WRITE;
        else                state_d = ST_FETCH;
      end
      ST_FILL: begin
        fb_write  = vis;
        fb_x      = cur_x[XW-2:0];
        fb_y      = cur_y[YW-2:0];
        fb_color  = color_q;
        fill_step = 1'b1;
        if (it_last) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gpu_blitter.sv
// tb_gpu_blitter: directed self-checking bench for gpu_blitter.
module tb_gpu_blitter;

  localparam int XW = 11;
  localparam int YW = 10;
`ifdef GPU_BLIT_FLIP_EN
  localparam bit FLIP_BUILT = 1'b1;
`else
  localparam bit FLIP_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_mode;
  logic [31:0] cmd_src_base;
  logic [15:0] cmd_src_x, cmd_src_y, cmd_src_stride;
  logic [XW-1:0] cmd_dst_x, cmd_w;
  logic [YW-1:0] cmd_dst_y, cmd_h;
  logic [15:0] cmd_color, cmd_key;
  logic        cmd_key_en, cmd_flip_x, cmd_flip_y;
  logic [XW-2:0] clip_x0, clip_x1;
  logic [YW-2:0] clip_y0, clip_y1;
  logic        mem_read, mem_valid;
  logic [31:0] mem_addr;
  logic [15:0] mem_data;
  logic        fb_write, done;
  logic [XW-2:0] fb_x;
  logic [YW-2:0] fb_y;
  logic [15:0] fb_color;

  gpu_blitter dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_mode       (cmd_mode),
    .cmd_src_base   (cmd_src_base),
    .cmd_src_x      (cmd_src_x),
    .cmd_src_y      (cmd_src_y),
    .cmd_src_stride (cmd_src_stride),
    .cmd_dst_x      (cmd_dst_x),
    .cmd_dst_y      (cmd_dst_y),
    .cmd_w          (cmd_w),
    .cmd_h          (cmd_h),
    .cmd_color      (cmd_color),
    .cmd_key        (cmd_key),
    .cmd_key_en     (cmd_key_en),
    .cmd_flip_x     (cmd_flip_x),
    .cmd_flip_y     (cmd_flip_y),
    .clip_x0        (clip_x0),
    .clip_x1        (clip_x1),
    .clip_y0        (clip_y0),
    .clip_y1        (clip_y1),
    .mem_read       (mem_read),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_valid      (mem_valid),
    .fb_write       (fb_write),
    .fb_x           (fb_x),
    .fb_y           (fb_y),
    .fb_color       (fb_color),
    .done           (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc      = 0;
  bit key_test = 1'b0;
  bit mem_age  = 1'b0;

  int wr_x[$], wr_y[$], wr_c[$], wr_t[$], rd_addr[$], done_t[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_img(input logic [31:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // Monitor and memory responder: reply one cycle after a request is first seen.
  always @(posedge clk) begin
    cyc++;
    #2;
    if (fb_write) begin
      wr_x.push_back(int'(fb_x));
      wr_y.push_back(int'(fb_y));
      wr_c.push_back(int'(fb_color));
      wr_t.push_back(cyc);
    end
    if (done) done_t.push_back(cyc);
    if (reset) begin
      mem_valid = 1'b0;
      mem_age   = 1'b0;
    end else if (mem_valid) begin
      mem_valid = 1'b0;
      mem_age   = mem_read;
    end else if (mem_read) begin
      if (mem_age) begin
        mem_data  = key_test ? ((rd_addr.size() == 0) ? 16'h0000 : 16'h1234) : mem_img(mem_addr);
        mem_valid = 1'b1;
        rd_addr.push_back(int'(mem_addr));
        mem_age   = 1'b0;
      end else begin
        mem_age = 1'b1;
      end
    end else begin
      mem_age = 1'b0;
    end
  end

  task automatic set_defaults();
    cmd_mode = 2'd3; cmd_src_base = '0; cmd_src_x = '0; cmd_src_y = '0;
    cmd_src_stride = '0; cmd_dst_x = '0; cmd_dst_y = '0; cmd_w = '0; cmd_h = '0;
    cmd_color = '0; cmd_key = '0; cmd_key_en = 1'b0; cmd_flip_x = 1'b0; cmd_flip_y = 1'b0;
    clip_x0 = '0; clip_x1 = 10'd400; clip_y0 = '0; clip_y1 = 9'd240;
  endtask

  task automatic clear_logs();
    wr_x.delete(); wr_y.delete(); wr_c.delete(); wr_t.delete();
    rd_addr.delete(); done_t.delete();
  endtask

  task automatic run_cmd(input int budget);
    clear_logs();
    @(negedge clk);
    cmd_valid = 1'b1;
    acc       = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < budget && done_t.size() == 0; k++) @(negedge clk);
    check_eq("done_count", done_t.size(), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ea;
    mem_valid = 1'b0;
    mem_data  = '0;
    cmd_valid = 1'b0;
    reset     = 1'b1;
    set_defaults();
    repeat (3) @(negedge clk);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_mem_read", mem_read, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_fb_write", fb_write, 0);
    check_eq("rst_fb_x", fb_x, 0);
    check_eq("rst_fb_y", fb_y, 0);
    check_eq("rst_fb_color", fb_color, 0);
    check_eq("rst_done", done, 0);
    reset = 1'b0;

    // FILL 3x2 at (10,20)
    set_defaults();
    cmd_mode = 2'd1; cmd_dst_x = 11'd10; cmd_dst_y = 10'd20; cmd_w = 11'd3; cmd_h = 10'd2;
    cmd_color = 16'hABCD;
    run_cmd(50);
    check_eq("fill_count", wr_x.size(), 6);
    for (int k = 0; k < 6 && k < wr_x.size(); k++) begin
      check_eq("fill_x", wr_x[k], 10 + k % 3);
      check_eq("fill_y", wr_y[k], 20 + k / 3);
      check_eq("fill_c", wr_c[k], 32'hABCD);
      check_eq("fill_t", wr_t[k], acc + k);
    end
    if (done_t.size() > 0) check_eq("fill_done_t", done_t[0], acc + 6);
    @(negedge clk);
    check_eq("fill_ready_back", cmd_ready, 1);

    // FILL with a narrowed clip window
    set_defaults();
    cmd_mode = 2'd1; cmd_dst_y = 10'd5; cmd_w = 11'd4; cmd_h = 10'd1; cmd_color = 16'h0001;
    clip_x0 = 10'd1; clip_x1 = 10'd3;
    run_cmd(50);
    check_eq("clip_count", wr_x.size(), 2);
    for (int k = 0; k < 2 && k < wr_x.size(); k++) begin
      check_eq("clip_x", wr_x[k], 1 + k);
      check_eq("clip_t", wr_t[k], acc + 1 + k);
    end

    // COPY 4x1, then the same with flip_x
    for (int f = 0; f < 2; f++) begin
      set_defaults();
      cmd_mode = 2'd0; cmd_src_base = 32'h1000; cmd_src_x = 16'd2; cmd_src_y = 16'd1;
      cmd_src_stride = 16'd8; cmd_dst_x = 11'd50; cmd_dst_y = 10'd60; cmd_w = 11'd4; cmd_h = 10'd1;
      cmd_flip_x = (f == 1);
      run_cmd(100);
      check_eq("copy_reads", rd_addr.size(), 4);
      check_eq("copy_writes", wr_x.size(), 4);
      for (int k = 0; k < 4 && k < rd_addr.size() && k < wr_x.size(); k++) begin
        ea = (f == 1 && FLIP_BUILT) ? 32'h101A - 32'(2 * k) : 32'h1014 + 32'(2 * k);
        check_eq("copy_addr", rd_addr[k], ea);
        check_eq("copy_x", wr_x[k], 50 + k);
        check_eq("copy_y", wr_y[k], 60);
        check_eq("copy_c", wr_c[k], {16'h0, mem_img(ea)});
        check_eq("copy_t", wr_t[k], acc + 2 + 2 * k);
      end
      if (done_t.size() > 0) check_eq("copy_done_t", done_t[0], acc + 9);
    end

    // COPY 2x2 straddling the left and bottom edges
    set_defaults();
    cmd_mode = 2'd0; cmd_src_base = 32'h2000; cmd_src_stride = 16'd4;
    cmd_dst_x = '1; cmd_dst_y = 10'd239; cmd_w = 11'd2; cmd_h = 10'd2;
    run_cmd(100);
    check_eq("edge_reads", rd_addr.size(), 4);
    if (rd_addr.size() == 4) check_eq("edge_addr3", rd_addr[3], 32'h200A);
    check_eq("edge_writes", wr_x.size(), 1);
    if (wr_x.size() > 0) begin
      check_eq("edge_x", wr_x[0], 0);
      check_eq("edge_y", wr_y[0], 239);
      check_eq("edge_c", wr_c[0], {16'h0, mem_img(32'h2002)});
    end

    // Colour key 0x0000 drops the first pixel only
    set_defaults();
    cmd_mode = 2'd0; cmd_src_base = 32'h3000; cmd_src_stride = 16'd16;
    cmd_dst_x = 11'd5; cmd_dst_y = 10'd5; cmd_w = 11'd2; cmd_h = 10'd1;
    cmd_key_en = 1'b1; cmd_key = 16'h0000;
    key_test = 1'b1;
    run_cmd(100);
    key_test = 1'b0;
    check_eq("key_reads", rd_addr.size(), 2);
    check_eq("key_writes", wr_x.size(), 1);
    if (wr_x.size() > 0) begin
      check_eq("key_x", wr_x[0], 6);
      check_eq("key_c", wr_c[0], 32'h1234);
    end

    // NOP and zero-width COPY complete at N+1 with no traffic
    set_defaults();
    run_cmd(20);
    if (done_t.size() > 0) check_eq("nop_done_t", done_t[0], acc);
    check_eq("nop_writes", wr_x.size(), 0);
    set_defaults();
    cmd_mode = 2'd0; cmd_w = '0; cmd_h = 10'd3;
    run_cmd(20);
    if (done_t.size() > 0) check_eq("w0_done_t", done_t[0], acc);
    check_eq("w0_reads", rd_addr.size(), 0);
    check_eq("w0_writes", wr_x.size(), 0);

    // CLEAR interrupted by reset after 100 writes
    set_defaults();
    cmd_mode = 2'd2; cmd_color = 16'h0F0F; cmd_dst_x = 11'd7; cmd_w = 11'd1; cmd_h = 10'd1;
    clear_logs();
    @(negedge clk);
    cmd_valid = 1'b1;
    acc       = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 300 && wr_x.size() < 100; k++) @(negedge clk);
    check_eq("clr_reached_100", wr_x.size(), 100);
    reset = 1'b1;
    @(negedge clk);
    check_eq("clr_rst_fb_write", fb_write, 0);
    check_eq("clr_rst_mem_read", mem_read, 0);
    check_eq("clr_rst_ready", cmd_ready, 1);
    check_eq("clr_rst_done", done, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("clr_no_done", done_t.size(), 0);
    check_eq("clr_total_writes", wr_x.size(), 100);
    if (wr_x.size() >= 100) begin
      check_eq("clr_first_x", wr_x[0], 0);
      check_eq("clr_first_t", wr_t[0], acc);
      check_eq("clr_x99", wr_x[99], 99);
      check_eq("clr_y99", wr_y[99], 0);
      check_eq("clr_c99", wr_c[99], 32'h0F0F);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
